mult_job_sched: RTL
===================

MULT_JOB_SCHED -- requirements
Module: mult_job_sched

Interface
REQ-001 SHALL have parameter DEPTH, default 4, job queue entries (power of two, >=2).
REQ-002 SHALL have parameter ADDR_W, default 3, width of ROM, RAM and job address fields.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-005 SHALL have ports job_valid in 1 / job_ready out 1  job handshake; a job is accepted on an edge where both are high.
REQ-006 SHALL have ports job_a, job_b, job_dst  in  ADDR_W each  ROM operand addresses and RAM destination.
REQ-007 SHALL have ports rd_req in 1 / rd_addr in ADDR_W / rd_gnt out 1  host RAM read request, address and one-cycle grant.
REQ-008 SHALL have port rom_addr  out  ADDR_W  ROM address.
REQ-009 SHALL have ports rf_w, rf_da, rf_sa, rf_sb  out  1 each  register-file write enable, destination and read selects.
REQ-010 SHALL have ports ram_we out 1 / ram_addr out ADDR_W  RAM write enable and address.
REQ-011 SHALL have ports busy out 1, done out 1, st_out out 3  not-IDLE flag, job-complete pulse, state code.

Function
REQ-012 SHALL queue accepted jobs {job_a,job_b,job_dst} in a DEPTH-entry FIFO; job_ready = not full.
REQ-013 SHALL allow push and pop on the same edge whenever not full; occupancy then stays unchanged.
REQ-014 SHALL implement states IDLE=0, LOAD_A=1, LOAD_B=2, MULT=3, WRITE=4, READ=5, driven on st_out.
REQ-015 IDLE: if FIFO non-empty and (rd_req low or last_read set) SHALL pop into a job register -> LOAD_A; else if rd_req -> READ; else stay.
REQ-016 last_read SHALL set on leaving READ and clear on leaving WRITE; a queued job therefore waits at most one read.
REQ-017 LOAD_A: rom_addr=job register a, rf_w=1, rf_da=0 -> LOAD_B.
REQ-018 LOAD_B: rom_addr=job register b, rf_w=1, rf_da=1 -> MULT.
REQ-019 MULT: rf_w=0, one settling cycle for the combinational product -> WRITE.
REQ-020 WRITE: ram_we=1, ram_addr=job register dst, done=1 for this cycle only -> IDLE.
REQ-021 READ: ram_we=0, ram_addr=rd_addr captured at the IDLE->READ edge, rd_gnt=1 this cycle only -> IDLE.
REQ-022 rf_sa SHALL be 0 and rf_sb SHALL be 1 in every state.
REQ-023 In states where they have no function, rom_addr, ram_addr, rf_da SHALL be 0 and rf_w, ram_we, done, rd_gnt SHALL be 0.
REQ-024 busy SHALL be high in every state except IDLE.
REQ-025 Latency: job accepted at edge E into an empty FIFO while IDLE and rd_req low -> LOAD_A in cycle after E+1, done high in the cycle after E+4.
REQ-026 Back-to-back jobs SHALL cost 5 cycles each (IDLE plus 4 work states).
REQ-027 job_valid while full SHALL be ignored with no corruption; rd_req outside IDLE SHALL be held by the requester until rd_gnt.

Reset
REQ-028 rst high SHALL immediately force IDLE, empty the FIFO, clear the job register and last_read, and drive every output to 0 except job_ready=1.
REQ-029 Reset mid-job SHALL abandon that job and all queued jobs; no RAM write SHALL occur after rst rises.

Structure
REQ-030 State encodings and the default DEPTH/ADDR_W values SHALL live in the shared package mult_pkg.
REQ-031 The queue SHALL be a separate sub-module job_fifo (parameterised DEPTH, width 3*ADDR_W, full/empty flags); the FSM stays in mult_job_sched.

Verification
REQ-032 Single job a=1, b=2, dst=5 with ROM 1->12, 2->6 -> RAM[5]=72, done one pulse, rom_addr 1 then 2.
REQ-033 Push DEPTH+1 jobs back-to-back with FSM busy -> job_ready low after DEPTH accepts, extra job dropped, all accepted jobs complete in order.
REQ-034 rd_req held high with 2 jobs queued -> states alternate READ, job, READ, job; no job starves.
REQ-035 rst asserted during LOAD_B -> st_out=0, ram_we=0 same cycle, FIFO empty, no later write to dst.
REQ-036 Simultaneous push and pop at occupancy 1 -> occupancy stays 1, popped and pushed entries both correct.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared constants for the multiply job scheduler: default geometry and the
// FSM state codes that appear on st_out.
package mult_pkg;

  localparam int unsigned DEPTH_DEF  = 4;
  localparam int unsigned ADDR_W_DEF = 3;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD_A = 3'd1;
  localparam logic [2:0] ST_LOAD_B = 3'd2;
  localparam logic [2:0] ST_MULT   = 3'd3;
  localparam logic [2:0] ST_WRITE  = 3'd4;
  localparam logic [2:0] ST_READ   = 3'd5;

endpackage

// File: rtl/job_fifo.sv
// Job queue: DEPTH-entry first-word-fall-through FIFO.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   push_i, din_i     write request and data (ignored while full)
//   pop_i             read request (ignored while empty); dout_o shows head
//   full_o, empty_o   occupancy flags
module job_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [PTR_W:0]   cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign dout_o  = mem_q[rptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: emptiness is defined by the counter alone.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din_i;
  end

endmodule

// File: rtl/mult_job_sched.sv
// Multiply job scheduler: queues {a,b,dst} jobs and sequences an external
// ROM / two-entry register file / multiplier / RAM datapath to compute
// RAM[dst] = ROM[a] * ROM[b]. Host RAM reads are interleaved with jobs.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   job_valid/job_ready           job handshake; job_a, job_b, job_dst payload
//   rd_req, rd_addr, rd_gnt       host RAM read request / address / grant
//   rom_addr                      ROM address
//   rf_w, rf_da, rf_sa, rf_sb     register-file write enable, dest, read selects
//   ram_we, ram_addr              RAM write enable and address
//   busy, done, st_out            not-IDLE, job-complete pulse, state code
module mult_job_sched
  import mult_pkg::*;
#(
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [ADDR_W-1:0] job_a,
  input  logic [ADDR_W-1:0] job_b,
  input  logic [ADDR_W-1:0] job_dst,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rf_w,
  output logic              rf_da,
  output logic              rf_sa,
  output logic              rf_sb,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              busy,
  output logic              done,
  output logic [2:0]        st_out
);

  localparam int unsigned JOB_W = 3 * ADDR_W;

  logic [2:0]        state_q, state_d;
  logic [JOB_W-1:0]  job_q, job_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              last_read_q, last_read_d;

  logic              fifo_pop, fifo_full, fifo_empty;
  logic [JOB_W-1:0]  fifo_dout;

  logic [ADDR_W-1:0] job_a_q, job_b_q, job_dst_q;

  assign job_a_q   = job_q[JOB_W-1 -: ADDR_W];
  assign job_b_q   = job_q[2*ADDR_W-1 -: ADDR_W];
  assign job_dst_q = job_q[ADDR_W-1:0];

  job_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (JOB_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (job_valid),
    .din_i   ({job_a, job_b, job_dst}),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign job_ready = ~fifo_full;

  // last_read gives a queued job priority over a held rd_req right after a
  // read, so reads and jobs alternate instead of either one starving.
  always_comb begin
    state_d     = state_q;
    job_d       = job_q;
    rd_addr_d   = rd_addr_q;
    last_read_d = last_read_q;
    fifo_pop    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && (!rd_req || last_read_q)) begin
          fifo_pop = 1'b1;
          job_d    = fifo_dout;
          state_d  = ST_LOAD_A;
        end else if (rd_req) begin
          rd_addr_d = rd_addr;
          state_d   = ST_READ;
        end
      end
      ST_LOAD_A: state_d = ST_LOAD_B;
      ST_LOAD_B: state_d = ST_MULT;
      ST_MULT:   state_d = ST_WRITE;
      ST_WRITE: begin
        last_read_d = 1'b0;
        state_d     = ST_IDLE;
      end
      ST_READ: begin
        last_read_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      job_q       <= '0;
      rd_addr_q   <= '0;
      last_read_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      job_q       <= job_d;
      rd_addr_q   <= rd_addr_d;
      last_read_q <= last_read_d;
    end
  end

  always_comb begin
    rom_addr = '0;
    ram_addr = '0;
    rf_w     = 1'b0;
    rf_da    = 1'b0;
    ram_we   = 1'b0;
    done     = 1'b0;
    rd_gnt   = 1'b0;
    case (state_q)
      ST_LOAD_A: begin
        rom_addr = job_a_q;
        rf_w     = 1'b1;
      end
      ST_LOAD_B: begin
        rom_addr = job_b_q;
        rf_w     = 1'b1;
        rf_da    = 1'b1;
      end
      ST_WRITE: begin
        ram_we   = 1'b1;
        ram_addr = job_dst_q;
        done     = 1'b1;
      end
      ST_READ: begin
        ram_addr = rd_addr_q;
        rd_gnt   = 1'b1;
      end
      default: ;
    endcase
  end

  // Read selects are fixed at 0/1 in every state; rf_sb is gated by rst so
  // all outputs except job_ready read 0 while reset is held.
  assign rf_sa  = 1'b0;
  assign rf_sb  = ~rst;
  assign busy   = (state_q != ST_IDLE);
  assign st_out = state_q;

endmodule
